// File: rtl/bsg_mem_2rw_gran_pkg.sv
// Shared helpers for the granule-masked dual-port RAM: collision kinds,
// mask-width derivation and per-granule even parity.
package bsg_mem_2rw_gran_pkg;

    localparam int unsigned max_gran_lp = 64;

    // rw_a: port A reads while port B writes the same word; rw_b is the mirror case.
    typedef enum logic [1:0] {
        e_coll_none,
        e_coll_ww,
        e_coll_rw_a,
        e_coll_rw_b
    } collision_kind_e;

    function automatic int unsigned mask_width_f(input int unsigned width, input int unsigned gran);
        return width / gran;
    endfunction

    // Narrower granules arrive zero-extended, which leaves the parity unchanged.
    function automatic logic even_parity_f(input logic [max_gran_lp-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/bsg_mem_2rw_gran_merge.sv
// Per-granule merge of old data with two masked sources; A wins where both
// masks are set, B fills granules only it covers, old data fills the rest.
module bsg_mem_2rw_gran_merge
    import bsg_mem_2rw_gran_pkg::*;
#(
    parameter int width_p     = 32,
    parameter int mask_gran_p = 8
) (
    input  logic [width_p-1:0]                          old_i,
    input  logic [width_p-1:0]                          a_data_i,
    input  logic [mask_width_f(width_p, mask_gran_p)-1:0] a_mask_i,
    input  logic [width_p-1:0]                          b_data_i,
    input  logic [mask_width_f(width_p, mask_gran_p)-1:0] b_mask_i,
    output logic [width_p-1:0]                          data_o
);

    localparam int mask_width_lp = mask_width_f(width_p, mask_gran_p);

    for (genvar gi = 0; gi < mask_width_lp; gi++) begin : g_gran
        assign data_o[gi*mask_gran_p +: mask_gran_p] =
            a_mask_i[gi] ? a_data_i[gi*mask_gran_p +: mask_gran_p] :
            b_mask_i[gi] ? b_data_i[gi*mask_gran_p +: mask_gran_p] :
                           old_i[gi*mask_gran_p +: mask_gran_p];
    end

endmodule

// File: rtl/bsg_mem_2rw_sync_mask_write_gran.sv
// True dual-port synchronous RAM with granule write masks and collision reporting.
// Define BSG_MEM_2RW_GRAN_PARITY_EN to store and check one even-parity bit per granule.
module bsg_mem_2rw_sync_mask_write_gran
    import bsg_mem_2rw_gran_pkg::*;
#(
    parameter int width_p                     = 32,
    parameter int els_p                       = 16,
    parameter int mask_gran_p                 = 8,
    parameter int read_write_same_addr_p      = 0,
    parameter int disable_collision_warning_p = 0,
    parameter int collision_cnt_width_p       = 8,
    localparam int addr_width_lp = $clog2(els_p),
    localparam int mask_width_lp = mask_width_f(width_p, mask_gran_p)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             a_v_i,
    input  logic                             a_w_i,
    input  logic [addr_width_lp-1:0]         a_addr_i,
    input  logic [width_p-1:0]               a_data_i,
    input  logic [mask_width_lp-1:0]         a_w_mask_i,
    input  logic                             b_v_i,
    input  logic                             b_w_i,
    input  logic [addr_width_lp-1:0]         b_addr_i,
    input  logic [width_p-1:0]               b_data_i,
    input  logic [mask_width_lp-1:0]         b_w_mask_i,
    input  logic                             clear_collision_i,
    output logic [width_p-1:0]               a_data_o,
    output logic                             a_v_o,
    output logic [width_p-1:0]               b_data_o,
    output logic                             b_v_o,
    output logic                             collision_o,
    output logic [collision_cnt_width_p-1:0] collision_cnt_o,
    output logic                             a_parity_err_o,
    output logic                             b_parity_err_o
);

    if (width_p % mask_gran_p != 0) begin : g_bad_gran
        $error("width_p (%0d) must be a multiple of mask_gran_p (%0d)", width_p, mask_gran_p);
    end
    if (els_p < 2) begin : g_bad_els
        $error("els_p (%0d) must be at least 2", els_p);
    end

    logic a_rd, a_wr, b_rd, b_wr, same_addr;
    collision_kind_e coll_kind;
    logic coll_any;

    assign a_rd      = a_v_i & ~a_w_i;
    assign a_wr      = a_v_i &  a_w_i;
    assign b_rd      = b_v_i & ~b_w_i;
    assign b_wr      = b_v_i &  b_w_i;
    assign same_addr = (a_addr_i == b_addr_i);

    always_comb begin
        coll_kind = e_coll_none;
        if (same_addr) begin
            if (a_wr && b_wr)      coll_kind = e_coll_ww;
            else if (a_rd && b_wr) coll_kind = e_coll_rw_a;
            else if (b_rd && a_wr) coll_kind = e_coll_rw_b;
        end
    end
    assign coll_any = (coll_kind != e_coll_none);

    logic [width_p-1:0] mem_q [els_p];

    // On a write-write collision port A carries the merged word and port B stays quiet.
    logic                     ww, b_wr_solo;
    logic [mask_width_lp-1:0] wa_b_mask, wa_mask;
    logic [width_p-1:0]       wa_data;

    assign ww        = (coll_kind == e_coll_ww);
    assign b_wr_solo = b_wr & ~ww;
    assign wa_b_mask = ww ? b_w_mask_i : '0;
    assign wa_mask   = a_w_mask_i | wa_b_mask;

    bsg_mem_2rw_gran_merge #(.width_p(width_p), .mask_gran_p(mask_gran_p)) wr_merge (
        .old_i    ('0),
        .a_data_i (a_data_i),
        .a_mask_i (a_w_mask_i),
        .b_data_i (b_data_i),
        .b_mask_i (wa_b_mask),
        .data_o   (wa_data)
    );

    always_ff @(posedge clk_i) begin
        for (int g = 0; g < mask_width_lp; g++) begin
            if (a_wr && wa_mask[g])
                mem_q[a_addr_i][g*mask_gran_p +: mask_gran_p] <= wa_data[g*mask_gran_p +: mask_gran_p];
            if (b_wr_solo && b_w_mask_i[g])
                mem_q[b_addr_i][g*mask_gran_p +: mask_gran_p] <= b_data_i[g*mask_gran_p +: mask_gran_p];
        end
    end

    // Only one port can be reading a word the other is writing, so one bypass merge serves both.
    logic                     byp_a, byp_b;
    logic [width_p-1:0]       byp_wdata, byp_data, a_rdata_d, b_rdata_d;
    logic [mask_width_lp-1:0] byp_mask;

    assign byp_a     = (read_write_same_addr_p != 0) && (coll_kind == e_coll_rw_a);
    assign byp_b     = (read_write_same_addr_p != 0) && (coll_kind == e_coll_rw_b);
    assign byp_wdata = (coll_kind == e_coll_rw_a) ? b_data_i   : a_data_i;
    assign byp_mask  = (coll_kind == e_coll_rw_a) ? b_w_mask_i : a_w_mask_i;

    bsg_mem_2rw_gran_merge #(.width_p(width_p), .mask_gran_p(mask_gran_p)) byp_merge (
        .old_i    (mem_q[a_addr_i]),
        .a_data_i (byp_wdata),
        .a_mask_i (byp_mask),
        .b_data_i ('0),
        .b_mask_i ('0),
        .data_o   (byp_data)
    );

    assign a_rdata_d = byp_a ? byp_data : mem_q[a_addr_i];
    assign b_rdata_d = byp_b ? byp_data : mem_q[b_addr_i];

    logic [width_p-1:0]               a_data_q, b_data_q;
    logic                             a_v_q, b_v_q, coll_q;
    logic [collision_cnt_width_p-1:0] coll_cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            a_data_q   <= '0;
            b_data_q   <= '0;
            a_v_q      <= 1'b0;
            b_v_q      <= 1'b0;
            coll_q     <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            a_v_q <= a_rd;
            b_v_q <= b_rd;
            if (a_rd) a_data_q <= a_rdata_d;
            if (b_rd) b_data_q <= b_rdata_d;
            if (clear_collision_i) begin
                coll_q     <= 1'b0;
                coll_cnt_q <= '0;
            end else if (coll_any) begin
                coll_q <= 1'b1;
                if (coll_cnt_q != '1) coll_cnt_q <= coll_cnt_q + collision_cnt_width_p'(1);
            end
        end
    end

    assign a_data_o        = a_data_q;
    assign a_v_o           = a_v_q;
    assign b_data_o        = b_data_q;
    assign b_v_o           = b_v_q;
    assign collision_o     = coll_q;
    assign collision_cnt_o = coll_cnt_q;

`ifdef BSG_MEM_2RW_GRAN_PARITY_EN
    if (mask_gran_p > max_gran_lp) begin : g_bad_par_gran
        $error("mask_gran_p (%0d) exceeds parity helper width", mask_gran_p);
    end

    logic [mask_width_lp-1:0] par_mem_q [els_p];
    logic [mask_width_lp-1:0] wa_par, b_par, byp_wpar, byp_par, a_chk_par, b_chk_par;
    logic [mask_width_lp-1:0] a_par_q, b_par_q, a_par_d, b_par_d;

    for (genvar gi = 0; gi < mask_width_lp; gi++) begin : g_par
        assign wa_par[gi]    = even_parity_f(max_gran_lp'(wa_data[gi*mask_gran_p +: mask_gran_p]));
        assign b_par[gi]     = even_parity_f(max_gran_lp'(b_data_i[gi*mask_gran_p +: mask_gran_p]));
        assign byp_wpar[gi]  = even_parity_f(max_gran_lp'(byp_wdata[gi*mask_gran_p +: mask_gran_p]));
        assign a_chk_par[gi] = even_parity_f(max_gran_lp'(a_data_q[gi*mask_gran_p +: mask_gran_p]));
        assign b_chk_par[gi] = even_parity_f(max_gran_lp'(b_data_q[gi*mask_gran_p +: mask_gran_p]));
    end

    // Bypassed granules take the writer's parity; untouched granules keep the stored bits.
    assign byp_par = (byp_mask & byp_wpar) | (~byp_mask & par_mem_q[a_addr_i]);
    assign a_par_d = byp_a ? byp_par : par_mem_q[a_addr_i];
    assign b_par_d = byp_b ? byp_par : par_mem_q[b_addr_i];

    always_ff @(posedge clk_i) begin
        for (int g = 0; g < mask_width_lp; g++) begin
            if (a_wr && wa_mask[g])         par_mem_q[a_addr_i][g] <= wa_par[g];
            if (b_wr_solo && b_w_mask_i[g]) par_mem_q[b_addr_i][g] <= b_par[g];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            a_par_q <= '0;
            b_par_q <= '0;
        end else begin
            if (a_rd) a_par_q <= a_par_d;
            if (b_rd) b_par_q <= b_par_d;
        end
    end

    assign a_parity_err_o = a_v_q & (|(a_chk_par ^ a_par_q));
    assign b_parity_err_o = b_v_q & (|(b_chk_par ^ b_par_q));
`else
    assign a_parity_err_o = 1'b0;
    assign b_parity_err_o = 1'b0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            if (a_v_i) assert ({1'b0, a_addr_i} < (addr_width_lp+1)'(els_p))
                else $error("port A address %0d out of range", a_addr_i);
            if (b_v_i) assert ({1'b0, b_addr_i} < (addr_width_lp+1)'(els_p))
                else $error("port B address %0d out of range", b_addr_i);
            if (read_write_same_addr_p == 0 && disable_collision_warning_p == 0 &&
                (coll_kind == e_coll_rw_a || coll_kind == e_coll_rw_b))
                $warning("read/write collision %s at address %0d: reader sees old data",
                         coll_kind.name(), a_addr_i);
        end
    end
`endif

endmodule
